// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch_fifo.sv
// fetch_fifo: small instruction buffer, power-of-two depth, with a synchronous
// clear that may load one entry in the same cycle.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      // clear wins over pop; a push alongside it becomes the sole entry
      rd_ptr <= '0;
      if (push) begin
        mem[0] <= push_data;
        wr_ptr <= PTR_W'(1);
        count  <= CNT_W'(1);
      end else begin
        wr_ptr <= '0;
        count  <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (!push_ok && pop_ok) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: single-outstanding memory requests feeding a small buffer.
// Optional FETCH_MISALIGN_CHECK_EN: a misaligned redirect yields one NOP entry
// flagged misalign and stalls fetch until the next redirect.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        misalign
);

`ifdef FETCH_MISALIGN_CHECK_EN
  localparam int ENTRY_W = 65;
`else
  localparam int ENTRY_W = 64;
`endif

  fetch_state_t       state;
  logic [31:0]        pc;
  logic [31:0]        req_addr;
  logic [31:0]        redir_pc;
  logic               redir_mis;
  logic               fetch_stall;
  logic               rsp_push;
  logic               mis_push;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_empty;
  logic               fifo_full;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head;

  // FIFO space is only checked in FETCH, where nothing is outstanding
  assign imem_req  = rst_n && (state == FETCH) && !fifo_full && !redirect_valid && !fetch_stall;
  assign imem_addr = pc;

  assign rsp_push    = (state == WAIT) && imem_rvalid && !redirect_valid;
  assign mis_push    = redirect_valid && redir_mis;
  assign fifo_push   = rsp_push || mis_push;
  assign instr_valid = !fifo_empty;
  assign fifo_pop    = instr_valid && instr_ready;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redir_pc  = redirect_pc;
  assign redir_mis = (redirect_pc[1:0] != 2'b00);
  assign push_data = mis_push ? {1'b1, redir_pc, INSTR_NOP} : {1'b0, req_addr, imem_rdata};
  assign {misalign, instr_pc, instr} = head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              fetch_stall <= 1'b0;
    else if (redirect_valid) fetch_stall <= redir_mis;
  end
`else
  logic unused_redir_lo;
  assign unused_redir_lo = ^redirect_pc[1:0];
  assign redir_pc    = {redirect_pc[31:2], 2'b00};
  assign redir_mis   = 1'b0;
  assign fetch_stall = 1'b0;
  assign push_data   = {req_addr, imem_rdata};
  assign {instr_pc, instr} = head;
  assign misalign    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      req_addr <= '0;
    end else if (redirect_valid) begin
      pc <= redir_pc;
    end else if (imem_req && imem_gnt) begin
      pc       <= pc + 32'd4;
      req_addr <= pc;
    end
  end

  // A response arriving with a redirect is simply not pushed, so nothing is left to flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:   if (imem_req && imem_gnt) state <= WAIT;
        WAIT:    if (imem_rvalid) state <= FETCH;
                 else if (redirect_valid) state <= FLUSH;
        FLUSH:   if (imem_rvalid) state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (redirect_valid),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a memory responder, randomized redirects and
// decoder backpressure, and a monitor checking the delivered instruction stream.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          FIFO_DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        misalign;

  instr_fetch #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .misalign       (misalign)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] b2w(input logic x);
    return {31'b0, x};
  endfunction

  // Program memory contents as a pure function of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        mis;
  } ent_t;

  ent_t exp_q[$];
  bit   stall_exp = 1'b0;
  int   pops_total = 0;

  // Expected stream after a restart at target: sequential words, or one NOP when misaligned
  task automatic load_expect(input logic [31:0] target);
    logic [31:0] a;
    ent_t        e;
    exp_q.delete();
    stall_exp = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    if (target[1:0] != 2'b00) begin
      e.instr = 32'h0000_0013;
      e.pc    = target;
      e.mis   = 1'b1;
      exp_q.push_back(e);
      stall_exp = 1'b1;
      return;
    end
`endif
    a = target & 32'hFFFF_FFFC;
    for (int i = 0; i < 64; i++) begin
      e.instr = mem_word(a);
      e.pc    = a;
      e.mis   = 1'b0;
      exp_q.push_back(e);
      a = a + 32'd4;
    end
  endtask

  // Memory responder: random grant, response 1..3 cycles after each grant
  int          gnt_force = 1;
  int          lat_force = 1;
  bit          pending = 1'b0;
  int          wcnt = 0;
  logic [31:0] paddr = '0;
  int          grants = 0;

  initial begin
    logic        g;
    logic [31:0] ga;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      g  = rst_n && imem_req && imem_gnt;
      ga = imem_addr;
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (g) begin
        check("one_outstanding", b2w(pending), 32'd0);
        pending = 1'b1;
        grants++;
        paddr = ga;
        wcnt  = ((lat_force > 0) ? lat_force : int'($urandom_range(1, 3))) - 1;
      end
      if (pending) begin
        if (wcnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(paddr);
          pending     = 1'b0;
        end else begin
          wcnt--;
        end
      end
      imem_gnt = (gnt_force >= 0) ? gnt_force[0] : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks hold rules
  initial begin
    ent_t        e;
    logic        prev_rst = 1'b0, prev_req = 1'b0, prev_gnt = 1'b0, prev_valid = 1'b0;
    logic        prev_ready = 1'b0, prev_redir = 1'b0, prev_mis = 1'b0;
    logic [31:0] prev_addr = '0, prev_instr = '0, prev_pc = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (instr_valid && instr_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_instr: got pc %h instr %h, expected none", instr_pc, instr);
          end else begin
            e = exp_q.pop_front();
            check("instr", instr, e.instr);
            check("instr_pc", instr_pc, e.pc);
            check("misalign", b2w(misalign), b2w(e.mis));
            pops_total++;
          end
        end
        if (prev_rst && prev_req && !prev_gnt && !redirect_valid) begin
          check("req_hold", b2w(imem_req), 32'd1);
          check("addr_hold", imem_addr, prev_addr);
        end
        if (prev_rst && prev_valid && !prev_ready && !prev_redir) begin
          check("hold_valid", b2w(instr_valid), 32'd1);
          check("hold_instr", instr, prev_instr);
          check("hold_pc", instr_pc, prev_pc);
          check("hold_mis", b2w(misalign), b2w(prev_mis));
        end
        if (stall_exp) check("stall_no_req", b2w(imem_req), 32'd0);
      end
      prev_rst   = rst_n;
      prev_req   = imem_req;
      prev_gnt   = imem_gnt;
      prev_addr  = imem_addr;
      prev_valid = instr_valid;
      prev_ready = instr_ready;
      prev_redir = redirect_valid;
      prev_instr = instr;
      prev_pc    = instr_pc;
      prev_mis   = misalign;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_redirect(input logic [31:0] t);
    instr_ready    = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = t;
    load_expect(t);
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_req"}, b2w(imem_req), 32'd0);
    check({tag, "_instr_valid"}, b2w(instr_valid), 32'd0);
    check({tag, "_misalign"}, b2w(misalign), 32'd0);
    check({tag, "_instr"}, instr, 32'd0);
    check({tag, "_instr_pc"}, instr_pc, 32'd0);
    check({tag, "_imem_addr"}, imem_addr, RESET_PC);
  endtask

  initial begin
    logic [31:0] a0;
    logic [31:0] t;
    bit          found;
    int          since;
    rst_n          = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    load_expect(RESET_PC);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");

    // Release with grant always high and single-cycle memory
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("req_after_reset", b2w(imem_req), 32'd1);
    check("addr_after_reset", imem_addr, RESET_PC);
    @(negedge clk);
    check("valid_before_latency", b2w(instr_valid), 32'd0);
    @(negedge clk);
    check("valid_after_latency", b2w(instr_valid), 32'd1);
    check("first_instr_pc", instr_pc, RESET_PC);

    // Decoder stalled: buffer fills, fetch stops with pc at +8
    repeat (10) @(negedge clk);
    check("full_grants", grants, 32'd2);
    check("full_no_req", b2w(imem_req), 32'd0);
    check("full_pc", imem_addr, RESET_PC + 32'd8);

    // Free one slot, catch the +8 fetch outstanding, redirect away from it
    step();
    instr_ready = 1'b1;
    lat_force   = 3;
    step();
    instr_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (pending && paddr == RESET_PC + 32'd8) found = 1'b1;
    end
    check("fetch8_outstanding", b2w(found), 32'd1);
    do_redirect(32'h0000_0100);
    lat_force = 1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (instr_valid) found = 1'b1;
    end
    check("redirect_valid_seen", b2w(found), 32'd1);
    check("redirect_first_pc", instr_pc, 32'h0000_0100);
    step();
    instr_ready = 1'b1;
    repeat (10) step();

    // Grant withheld: request and address must hold, pc moves only on grant
    gnt_force = 0;
    repeat (5) step();
    @(negedge clk);
    a0 = imem_addr;
    check("nogrant_req", b2w(imem_req), 32'd1);
    repeat (3) @(negedge clk);
    check("nogrant_addr", imem_addr, a0);
    step();
    gnt_force = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("grant_pc_step", imem_addr, a0 + 32'd4);
    step();

    // Misaligned redirect
    do_redirect(32'h0000_0102);
    instr_ready = 1'b1;
    repeat (20) step();
`ifdef FETCH_MISALIGN_CHECK_EN
    check("nop_consumed", exp_q.size(), 32'd0);
`endif
    do_redirect(32'h0000_0200);

    // Randomized traffic
    gnt_force = -1;
    lat_force = 0;
    since = 0;
    for (int c = 0; c < 3000; c++) begin
      since++;
      if (since > 35 || $urandom_range(0, 15) == 0) begin
        t = $urandom;
        case ($urandom_range(0, 3))
          0:       t = t & 32'h0000_0FFC;
          1:       t = 32'hFFFF_FFF0 + (t & 32'h0000_000C);
          2:       t = t;
          default: t = t & 32'hFFFF_FFFC;
        endcase
        do_redirect(t);
        since = 0;
      end else begin
        instr_ready = ($urandom_range(0, 3) != 0);
        step();
      end
    end

    // Reset while a request is outstanding; its late response must be ignored
    instr_ready = 1'b0;
    gnt_force   = 1;
    lat_force   = 3;
    do_redirect(32'h0000_0040);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (pending) found = 1'b1;
    end
    check("wait_before_reset", b2w(found), 32'd1);
    gnt_force = 0;
    rst_n     = 1'b0;
    load_expect(RESET_PC);
    @(negedge clk);
    check_reset_outputs("midwait_reset");
    step();
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("stale_rsp_ignored", b2w(instr_valid), 32'd0);
    check("restart_req", b2w(imem_req), 32'd1);
    check("restart_addr", imem_addr, RESET_PC);
    step();
    gnt_force   = -1;
    lat_force   = 0;
    instr_ready = 1'b1;
    repeat (40) step();

    check("progress", b2w(pops_total > 100), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, the instruction buffer entries (power of two, at least 2).
REQ-003 SHALL use one clock and an asynchronous active-low reset, as the ports below define.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 imem_req  out  1  fetch request to instruction memory.
REQ-007 imem_addr  out  32  fetch byte address.
REQ-008 imem_gnt  in  1  request accepted this cycle.
REQ-009 imem_rvalid  in  1  read data valid.
REQ-010 imem_rdata  in  32  fetched instruction word.
REQ-011 redirect_valid  in  1  branch or jump taken; restart fetch.
REQ-012 redirect_pc  in  32  redirect target.
REQ-013 instr_valid  out  1  instr and instr_pc hold a valid instruction for the decoder.
REQ-014 instr_ready  in  1  decoder accepts the instruction.
REQ-015 instr  out  32  instruction word; bits [6:0], [14:12] and [31:25] feed opcode, funct3 and funct7.
REQ-016 instr_pc  out  32  address of instr.
REQ-017 misalign  out  1  head entry comes from a misaligned redirect.

Function
REQ-018 SHALL hold a pc register and a FIFO of {instr, pc, misalign} entries, FIFO_DEPTH deep.
REQ-019 SHALL implement an FSM with three states:
- FETCH: no request outstanding.
- WAIT: one request outstanding.
- FLUSH: the outstanding response is to be discarded.
REQ-020 SHALL assert imem_req in FETCH only when fifo_count + outstanding < FIFO_DEPTH and no redirect_valid is present; imem_addr = pc.
REQ-021 SHALL hold imem_req and imem_addr stable until imem_gnt; on imem_req && imem_gnt, pc <= pc + 4 (wraps modulo 2^32) and FSM -> WAIT.
REQ-022 SHALL never have more than one request outstanding.
REQ-023 In WAIT, on imem_rvalid, SHALL push {imem_rdata, fetched address, 0} and go to FETCH; the next request may issue in that same cycle.
REQ-024 SHALL drive instr_valid = FIFO not empty, with instr, instr_pc and misalign taken from the FIFO head.
REQ-025 SHALL pop the FIFO on instr_valid && instr_ready.
REQ-026 SHALL keep instr, instr_pc and misalign stable while instr_valid && !instr_ready.
REQ-027 SHALL give a latency of 1 cycle from imem_rvalid to instr_valid when the FIFO is empty; there is no combinational path from imem_rdata to instr.
REQ-028 On redirect_valid SHALL, in the same cycle:
- load pc <= redirect_pc;
- clear the FIFO (the flush overrides any pop or push that cycle);
- go to FLUSH if a request is outstanding or is granted that cycle, otherwise to FETCH.
REQ-029 In FLUSH SHALL drop the next imem_rvalid without pushing, then go to FETCH.
REQ-030 A redirect in FLUSH SHALL update pc and keep the FSM in FLUSH.
REQ-031 SHALL give the FIFO simultaneous push and pop at full or empty the correct net count; the FIFO never overflows because REQ-020 reserves space.

Reset
REQ-032 While rst_n = 0 SHALL force:
- pc = RESET_PC, FSM = FETCH, FIFO empty, outstanding = 0;
- imem_req = 0, instr_valid = 0, misalign = 0;
- instr = 0, instr_pc = 0.
REQ-033 SHALL assert imem_req in the first clock edge cycle after rst_n deasserts.
REQ-034 A reset during WAIT SHALL abandon the request; a later imem_rvalid is ignored until a request is issued.

Configuration
REQ-035 With FETCH_MISALIGN_CHECK_EN defined, a redirect with redirect_pc[1:0] != 0 SHALL:
- issue no fetch;
- push one entry {INSTR_NOP, redirect_pc, 1};
- stall further fetching until the next redirect.
REQ-036 Without FETCH_MISALIGN_CHECK_EN, redirect_pc[1:0] SHALL be forced to 0 and misalign SHALL be tied to 0.

Structure
REQ-037 The shared package pkg SHALL hold the fetch_state_t enum (FETCH, WAIT, FLUSH) and INSTR_NOP = 32'h0000_0013.
REQ-038 The FIFO SHALL be a sub-module fetch_fifo, parameterized by width and depth, with an active-low asynchronous reset and a synchronous clear.

Verification
REQ-039 Release reset with RESET_PC=0, imem_gnt=1 and rvalid one cycle after each gnt -> addresses 0, 4, 8 in order; the first instr_valid has instr_pc=0.
REQ-040 Hold instr_ready=0 -> at most 2 requests complete, then imem_req=0; set instr_ready=1 -> fetching resumes at pc=8.
REQ-041 Redirect to 0x100 while the fetch of 0x8 is outstanding -> the 0x8 response is dropped and the next instr_pc is 0x100.
REQ-042 Hold imem_gnt=0 for 3 cycles -> imem_req and imem_addr stay stable; pc advances only after the grant.
REQ-043 With FETCH_MISALIGN_CHECK_EN defined, redirect to 0x102 -> one entry with instr=0x00000013, instr_pc=0x102, misalign=1, and no imem_req until the next redirect.
REQ-044 Assert rst_n=0 during WAIT -> all outputs return to reset values; fetch restarts at RESET_PC.
